// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning stage: button bit indices
// and the raw button vector type.
package btn_pkg;

    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_UP    = 2;
    localparam int unsigned BTN_DOWN  = 3;
    localparam int unsigned BTN_SHOOT = 4;
    localparam int unsigned BTN_START = 5;
    localparam int unsigned N_BTN     = 6;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage : btn_pkg

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser, stability counter, and a
// registered rising-edge pulse one cycle after the debounced level goes high.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    if (DEBOUNCE_CYCLES == 0 || (64'(1) << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_cnt_range
        $error("btn_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_rise;
    logic             w_mismatch;
    logic             w_done;

    assign w_mismatch = (r_sync2 != r_stable);
    assign w_done     = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept the synchronised level only after it has disagreed for a full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_mismatch) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_d <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule : btn_debounce

// File: rtl/btn_conditioner.sv
// Board button front end: debounces six buttons, produces direction levels,
// a frame-held shoot request and a start-toggled run enable (BTN_AUTOFIRE_EN adds autofire).
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned AUTOFIRE_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             frame_tick,
    input  logic             halt,
    output logic [3:0]       press,
    output logic             shoot_req,
    output logic             run,
    output logic [N_BTN-1:0] btn_stable
);

    if (AUTOFIRE_FRAMES == 0) begin : g_af_range
        $error("btn_conditioner: AUTOFIRE_FRAMES must be nonzero");
    end

    btn_vec_t w_stable;
    btn_vec_t w_rise;
    logic     w_af_hit;
    logic     w_unused_rise;
    logic     r_shoot_req;
    logic     r_run;

    for (genvar gi = 0; gi < int'(N_BTN); gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (btn_raw[gi]),
            .o_stable(w_stable[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    // Direction buttons only need levels; their edge pulses are not consumed.
    assign w_unused_rise = ^w_rise[BTN_DOWN:BTN_RIGHT];

`ifdef BTN_AUTOFIRE_EN
    localparam int unsigned AF_W = $clog2(AUTOFIRE_FRAMES + 1);

    logic [AF_W-1:0] r_af_cnt;

    assign w_af_hit = frame_tick && w_stable[BTN_SHOOT] && !w_rise[BTN_SHOOT]
                      && (r_af_cnt == AF_W'(AUTOFIRE_FRAMES - 1));

    // Counts frames while shoot is held; a fresh press restarts the interval.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_af_cnt <= '0;
        end else if (!w_stable[BTN_SHOOT] || w_rise[BTN_SHOOT]) begin
            r_af_cnt <= '0;
        end else if (frame_tick) begin
            r_af_cnt <= w_af_hit ? '0 : r_af_cnt + AF_W'(1);
        end
    end
`else
    assign w_af_hit = 1'b0;
`endif

    // Set beats clear so a request raised on a tick survives to the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shoot_req <= 1'b0;
        end else if (w_rise[BTN_SHOOT] || w_af_hit) begin
            r_shoot_req <= 1'b1;
        end else if (frame_tick) begin
            r_shoot_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else if (halt) begin
            r_run <= 1'b0;
        end else if (w_rise[BTN_START]) begin
            r_run <= ~r_run;
        end
    end

    assign press      = w_stable[BTN_DOWN:BTN_RIGHT];
    assign btn_stable = w_stable;
    assign shoot_req  = r_shoot_req;
    assign run        = r_run;

endmodule : btn_conditioner
